stepper_drive_seq: RTL and testbench

- Parametrised successor to the fixed quadrature stepper sequencer that is clocked from a divided counter bit.
- Drives one bipolar stepper's four coil lines (A, B, AN, BN) from a single CLOCK_50 domain.
- Supports programmable step period, wave, full and half-step modes, counted moves with a ready/valid command handshake, a stop input, an enable gate and a signed position counter.
- Sits between a control source (switch/keys, later a soft core or ADC-driven loop) and the GPIO header pins.

---
 rtl/stepper_drive_seq.sv | 130 +++++++++++++
 tb/tb_stepper_drive_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_drive_seq.sv
// Bipolar stepper coil sequencer.
// Counted moves, wave/full/half modes, position tracking.
`timescale 1ns/1ps
module stepper_drive_seq #(
  parameter int PER_W  = 24,
  parameter int STEP_W = 16,
  parameter int POS_W  = 32
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [PER_W-1:0]        period,
  input  logic                    move_valid,
  output logic                    move_ready,
  input  logic [STEP_W-1:0]       move_steps,
  input  logic                    move_dir,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position,
  output logic [3:0]              coil
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [2:0]        idx;
  logic [2:0]        idx_nxt;
  logic [2:0]        step_sz;
  logic [PER_W-1:0]  cnt;
  logic [PER_W-1:0]  per_q;
  logic [STEP_W-1:0] rem;
  logic              dir_q;
  logic [1:0]        mode_q;
  logic              accept;
  logic              step_go;

  function automatic logic [3:0] coil_of(input logic [2:0] i);
    case (i)
      3'd0:    coil_of = 4'b0001;
      3'd1:    coil_of = 4'b0011;
      3'd2:    coil_of = 4'b0010;
      3'd3:    coil_of = 4'b0110;
      3'd4:    coil_of = 4'b0100;
      3'd5:    coil_of = 4'b1100;
      3'd6:    coil_of = 4'b1000;
      default: coil_of = 4'b1001;
    endcase
  endfunction

  assign move_ready = (state == S_IDLE);
  assign busy       = (state == S_RUN);
  assign accept     = move_valid && move_ready;
  assign step_go    = busy && enable && !stop
                   && (cnt == '0);

  // Step size: wave wants even index, full wants odd; wrong parity realigns by one
  always_comb begin
    step_sz = 3'd1;
    unique case (1'b1)
      mode_q == 2'd0: step_sz = idx[0] ? 3'd1 : 3'd2;
      mode_q == 2'd1: step_sz = idx[0] ? 3'd2 : 3'd1;
      default:        step_sz = 3'd1;
    endcase
  end

  // Next sequence index, so the coils track the index on the same edge
  always_comb begin
    idx_nxt = idx;
    if (step_go)
      idx_nxt = dir_q ? idx + step_sz : idx - step_sz;
  end

  // Move FSM, period counter, position and registered coil drive
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      per_q    <= '0;
      rem      <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 2'd0;
      done     <= 1'b0;
      position <= '0;
      coil     <= 4'b0000;
    end else begin
      done <= 1'b0;
      idx  <= idx_nxt;
      coil <= enable ? coil_of(idx_nxt) : 4'b0000;
      case (state)
        S_IDLE: begin
          if (accept) begin
            dir_q  <= move_dir;
            mode_q <= mode;
            per_q  <= (period == '0) ? PER_W'(1) : period;
            cnt    <= (period == '0) ? '0
                    : period - PER_W'(1);
            rem    <= move_steps;
            if (move_steps == '0)
              done  <= 1'b1;
            else
              state <= S_RUN;
          end
        end
        default: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (enable) begin
            if (cnt == '0) begin
              position <= dir_q ? position + POS_W'(1)
                                : position - POS_W'(1);
              rem <= rem - STEP_W'(1);
              cnt <= per_q - PER_W'(1);
              if (rem == STEP_W'(1)) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt - PER_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_drive_seq.sv
// Scoreboard bench for stepper_drive_seq.
// Expected steps queued at command time, checked as steps appear.
`timescale 1ns/1ps
module tb_stepper_drive_seq;

  localparam int PER_W  = 24;
  localparam int STEP_W = 16;
  localparam int PW     = 8;

  logic                 clk = 1'b0;
  logic                 RESET = 1'b1;
  logic                 enable = 1'b1;
  logic [1:0]           mode = 2'd2;
  logic [PER_W-1:0]     period = '0;
  logic                 move_valid = 1'b0;
  logic                 move_ready;
  logic [STEP_W-1:0]    move_steps = '0;
  logic                 move_dir = 1'b1;
  logic                 stop = 1'b0;
  logic                 busy;
  logic                 done;
  logic signed [PW-1:0] position;
  logic [3:0]           coil;

  stepper_drive_seq #(
    .PER_W(PER_W), .STEP_W(STEP_W), .POS_W(PW)
  ) dut (
    .CLOCK_50(clk), .RESET(RESET), .enable(enable),
    .mode(mode), .period(period),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_steps(move_steps), .move_dir(move_dir),
    .stop(stop), .busy(busy), .done(done),
    .position(position), .coil(coil)
  );

  always #10 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic [3:0]           coil;
    logic signed [PW-1:0] pos;
    bit                   last;
  } exp_t;

  exp_t q[$];

  logic [3:0] TBL [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  logic signed [PW-1:0] prev_pos = '0;
  logic [2:0]           m_idx = '0;
  logic signed [PW-1:0] m_pos = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && position !== prev_pos) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step cyc=%0d pos=%0d", cyc, position);
      end else begin
        e = q.pop_front();
        if (coil !== e.coil || position !== e.pos
            || cyc != e.cyc || done !== e.last) begin
          n_bad++;
          $display("FAIL step got coil=%b pos=%0d cyc=%0d done=%b want coil=%b pos=%0d cyc=%0d done=%b",
                   coil, position, cyc, done, e.coil, e.pos, e.cyc, e.last);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    prev_pos = position;
  end

  function automatic void model_step(input bit d, input logic [1:0] md);
    logic [2:0] s;
    s = 3'd1;
    if (md == 2'd0 && m_idx[0] == 1'b0) s = 3'd2;
    if (md == 2'd1 && m_idx[0] == 1'b1) s = 3'd2;
    m_idx = d ? m_idx + s : m_idx - s;
    m_pos = d ? m_pos + PW'(1) : m_pos - PW'(1);
  endfunction

  task automatic issue(input int steps, input bit d, input logic [1:0] md,
                       input int p, input bit complete, input int n_push,
                       input int gap_after, input int gap_len, output int a);
    exp_t e;
    int pe;
    @(negedge clk);
    n_cmp++;
    if (move_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_cmd got=%b want=1", move_ready);
    end
    move_valid = 1'b1;
    move_steps = STEP_W'(steps);
    move_dir   = d;
    mode       = md;
    period     = PER_W'(p);
    a  = cyc + 1;
    pe = (p == 0) ? 1 : p;
    for (int k = 1; k <= n_push; k++) begin
      model_step(d, md);
      e.cyc  = a + k * pe + ((k > gap_after) ? gap_len : 0);
      e.coil = TBL[m_idx];
      e.pos  = m_pos;
      e.last = complete && (k == n_push);
      q.push_back(e);
    end
    @(negedge clk);
    move_valid = 1'b0;
    mode       = 2'd0;
    period     = PER_W'(7);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (coil !== 4'b0000 || position !== '0) begin
      n_bad++;
      $display("FAIL in_reset got coil=%b pos=%0d want 0000/0", coil, position);
    end
    RESET = 1'b0;
    q.delete();
    m_idx = '0;
    m_pos = '0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (coil !== 4'b0000 || busy !== 1'b0 || move_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold got coil=%b busy=%b ready=%b want 0000/0/1",
               coil, busy, move_ready);
    end
    RESET = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (coil !== 4'b0001 || position !== '0 || move_ready !== 1'b1
        || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got coil=%b pos=%0d ready=%b busy=%b done=%b want 0001/0/1/0/0",
               coil, position, move_ready, busy, done);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_half();
    int a;
    int d0;
    d0 = done_cnt;
    issue(10, 1'b1, 2'd2, 4, 1'b1, 10, 99, 0, a);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL half_busy got=%b want=1", busy);
    end
    drain(80);
    n_cmp++;
    if (position !== 8'sd10 || coil !== 4'b0010
        || done_cnt - d0 != 1 || busy !== 1'b0 || move_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL half_end got pos=%0d coil=%b dones=%0d busy=%b want 10/0010/1/0",
               position, coil, done_cnt - d0, busy);
    end
  endtask

  task automatic test_full_wave();
    int a;
    do_reset();
    issue(3, 1'b0, 2'd1, 3, 1'b1, 3, 99, 0, a);
    drain(40);
    n_cmp++;
    if (position !== -8'sd3 || coil !== 4'b0110) begin
      n_bad++;
      $display("FAIL full_end got pos=%0d coil=%b want -3/0110", position, coil);
    end
    issue(2, 1'b1, 2'd0, 2, 1'b1, 2, 99, 0, a);
    drain(40);
    n_cmp++;
    if (position !== -8'sd1 || coil !== 4'b1000) begin
      n_bad++;
      $display("FAIL wave_end got pos=%0d coil=%b want -1/1000", position, coil);
    end
  endtask

  task automatic test_stop();
    int a;
    int d0;
    logic signed [PW-1:0] p0;
    p0 = position;
    d0 = done_cnt;
    issue(8, 1'b1, 2'd2, 2, 1'b0, 3, 99, 0, a);
    while (cyc < a + 7) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || move_ready !== 1'b1
        || position !== p0 + PW'(3)) begin
      n_bad++;
      $display("FAIL stop_idle got busy=%b ready=%b pos=%0d want 0/1/%0d",
               busy, move_ready, position, p0 + PW'(3));
    end
    drain(10);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || position !== p0 + PW'(3)) begin
      n_bad++;
      $display("FAIL stop_after got dones=%0d pos=%0d want 0/%0d",
               done_cnt - d0, position, p0 + PW'(3));
    end
  endtask

  task automatic test_enable_gap();
    int a;
    int d0;
    logic signed [PW-1:0] p0;
    p0 = position;
    d0 = done_cnt;
    issue(4, 1'b1, 2'd2, 5, 1'b1, 4, 2, 20, a);
    while (cyc < a + 11) @(negedge clk);
    enable = 1'b0;
    while (cyc < a + 21) @(negedge clk);
    n_cmp++;
    if (coil !== 4'b0000 || position !== p0 + PW'(2) || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL gap got coil=%b pos=%0d busy=%b want 0000/%0d/1",
               coil, position, busy, p0 + PW'(2));
    end
    while (cyc < a + 31) @(negedge clk);
    enable = 1'b1;
    drain(40);
    n_cmp++;
    if (position !== p0 + PW'(4) || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL gap_end got pos=%0d dones=%0d want %0d/1",
               position, done_cnt - d0, p0 + PW'(4));
    end
  endtask

  task automatic test_period0();
    int a;
    logic signed [PW-1:0] p0;
    p0 = position;
    issue(3, 1'b1, 2'd2, 0, 1'b1, 3, 99, 0, a);
    drain(20);
    n_cmp++;
    if (position !== p0 + PW'(3)) begin
      n_bad++;
      $display("FAIL period0 got pos=%0d want %0d", position, p0 + PW'(3));
    end
  endtask

  task automatic test_steps0();
    int a;
    logic [3:0] c0;
    logic signed [PW-1:0] p0;
    c0 = coil;
    p0 = position;
    issue(0, 1'b1, 2'd2, 3, 1'b1, 0, 99, 0, a);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL steps0_done got done=%b busy=%b want 1/0", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || coil !== c0 || position !== p0
        || move_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL steps0_after got done=%b coil=%b pos=%0d ready=%b want 0/%b/%0d/1",
               done, coil, position, move_ready, c0, p0);
    end
  endtask

  task automatic test_wrap();
    int a;
    do_reset();
    issue(130, 1'b1, 2'd2, 1, 1'b1, 130, 999, 0, a);
    drain(200);
    n_cmp++;
    if (position !== -8'sd126) begin
      n_bad++;
      $display("FAIL wrap got pos=%0d want -126", position);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    issue(10, 1'b1, 2'd2, 2, 1'b1, 10, 99, 0, a);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    RESET = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (coil !== 4'b0000 || position !== '0 || busy !== 1'b0
        || move_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid got coil=%b pos=%0d busy=%b ready=%b want 0000/0/0/1",
               coil, position, busy, move_ready);
    end
    RESET = 1'b0;
    q.delete();
    m_idx = '0;
    m_pos = '0;
    @(negedge clk);
    mon_en = 1'b1;
    n_cmp++;
    if (coil !== 4'b0001 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_after got coil=%b busy=%b want 0001/0", coil, busy);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_full_wave();
    test_stop();
    test_enable_gap();
    test_period0();
    test_steps0();
    test_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
